uart_fifo_ctrl: RTL
===================

# uart_fifo_ctrl

Parametrised, FIFO-buffered UART peripheral that replaces the single-register `uart` on the data-memory bus. It adds the following over `uart`:
- independent TX/RX FIFOs;
- configurable data width, parity and stop bits;
- 16x-oversampled receive with error detection;
- internal loopback and a level interrupt.

The bus side keeps the `uart_sel`/`uart_wr_enable`/`uart_addr`/`wdata_mem`/`uart_data` convention so it drops into the existing memory map.

## Interface
- DATA_BITS, 8: character width, legal 5..8.
- TX_DEPTH, 16: TX FIFO entries, power of two, ≥2.
- RX_DEPTH, 16: RX FIFO entries, power of two, ≥2.
- BAUD_RST, 16'd0: reset value of BAUD register.
- clock  input  1  single clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- uart_sel  input  1  peripheral selected this cycle.
- uart_wr_enable  input  1  write strobe, valid with uart_sel.
- uart_addr  input  4  register address.
- wdata_mem  input  32  write data.
- uart_data  output  32  read data, combinational from uart_addr and current state.
- rx_bit  input  1  serial input, asynchronous, idle high.
- tx_bit  output  1  serial output, idle high.
- irq  output  1  level interrupt = |(STATUS[7:0] & IE[7:0]).

## Operation

Register map (unlisted addresses read 0; writes to them are ignored):
- 0x0 CTRL (R/W), reset 0x03.
  - b0 tx_en, b1 rx_en.
  - b2 par_en, b3 par_odd.
  - b4 two_stop, b5 loopback.
- 0x1 TXDATA (W): a write pushes wdata_mem[DATA_BITS-1:0].
  - If TX is full, the write is dropped and tx_ovf is set.
- 0x2 RXDATA (R): returns {zeros, data} and pops exactly one entry per select cycle.
  - A read while RX is empty returns 0 and does not pop.
- 0x3 BAUD (R/W) [15:0]: oversample tick every BAUD+1 clocks. One bit = 16 ticks.
- 0x4 STATUS (R; write 1 to clear the sticky bits).
  - b0 rx_nonempty, b1 tx_empty, b2 tx_ovf*, b3 rx_ovr*, b4 frame_err*, b5 par_err*.
  - b6 tx_idle, b7 rx_full.
  - [15:8] RX count, [23:16] TX count (each saturates at depth).
  - * marks sticky bits.
- 0x5 IE (R/W) [7:0], reset 0.

Frame format: LSB first.
- start (0), DATA_BITS data bits, optional parity, 1 or 2 stop bits (1).
- Even parity: parity bit = XOR of data. Odd parity: its complement.

TX FSM: IDLE → START → DATA → PARITY (skipped if !par_en) → STOP → IDLE.
- Leaves IDLE when tx_en=1 and the FIFO is non-empty; pops on entry to START.
- Each state lasts 16 ticks, or 32 ticks in STOP when two_stop=1.
- Back-to-back characters: no idle gap.
- Clearing tx_en finishes the current frame, then holds IDLE.

RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
- rx_bit passes through a 2-flop synchroniser.
- In loopback, the RX input is internal tx and tx_bit is held 1.
- Falling edge in IDLE with rx_en=1 starts the tick counter.
- At tick 8 of START: if the line is high, this is a false start → IDLE.
- Data bits are sampled at mid-bit (tick 8 of each bit).
- STOP sample 0 → frame_err; the character is still pushed.
- Parity mismatch → par_err; the character is still pushed.
- Push into a full RX FIFO → discard and set rx_ovr.
- Only the first stop bit is checked.

Baud generator:
- 16-bit down-counter, reloaded from BAUD.
- A write to BAUD reloads immediately.

Simultaneous events:
- Push and pop on the same FIFO in the same cycle: both occur and the count is unchanged.
- Pop when full and push simultaneously is legal.
- W1C of a sticky bit in the same cycle as a new set event: set wins.

## Timing
- All outputs during/after reset: tx_bit=1, irq=0, uart_data reflects reset registers.
  - FIFOs empty, FSMs IDLE, STATUS=0x02 (tx_empty).
- Register write takes effect at the clock edge ending the select cycle.
- TX start latency: start bit drives tx_bit within 1 clock + ≤(BAUD+1) clocks of the TXDATA write edge.
- Tick alignment: tx_bit changes are registered, one clock after the tick.
- RX push: occurs at the mid-sample of the first stop bit.
  - rx_nonempty is visible the next cycle.
- Reset asserted mid-frame: tx_bit is forced to 1 immediately (asynchronous); the FIFO contents are lost.

## Test plan
- Reset: reset=0 for 5 clocks → tx_bit=1, irq=0, STATUS reads 0x00000002, CTRL reads 0x03.
- 8N1 TX at BAUD=0 (16 clocks/bit): write 0x41 to TXDATA.
  - tx_bit: 0 for 16 clocks, then 1,0,0,0,0,0,1,0 each 16 clocks, then 1.
  - Frame is 160 clocks; tx_idle returns.
- Loopback 8E2: CTRL=0x37, push 0x55, 0xA3.
  - RXDATA reads 0x55 then 0xA3; no error bits.
  - Frames are back to back: 192 clocks each.
- Overflow:
  - 17 TXDATA writes with tx_en=0 → TX count 16, tx_ovf=1.
  - With IE=0x04 → irq=1.
  - Writing STATUS=0x04 clears tx_ovf and irq.
- RX errors (BAUD=0, 8O1):
  - Drive 0x5A with wrong parity → par_err=1, data 0x5A stored.
  - Drive a frame with the stop bit low → frame_err=1.
  - Glitch low for 4 clocks → no push.
- Reset mid-frame: assert reset at clock 40 of a TX frame → tx_bit=1 within the same cycle; after release, TX count is 0 and no residual frame is sent.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: FIFO-buffered UART with 16x oversampled RX, parity/stop options,
// loopback and level irq. Ports: clock, reset (async, low), uart_sel/uart_wr_enable/
// uart_addr/wdata_mem in, uart_data out (comb read), rx_bit in, tx_bit out, irq out.
module uart_fifo_ctrl #(
    parameter int          DATA_BITS = 8,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [15:0] BAUD_RST  = 16'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_sel,
    input  logic        uart_wr_enable,
    input  logic [3:0]  uart_addr,
    input  logic [31:0] wdata_mem,
    output logic [31:0] uart_data,
    input  logic        rx_bit,
    output logic        tx_bit,
    output logic        irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    // Bus decode
    logic w_wr, w_rd;
    logic w_wr_ctrl, w_wr_txd, w_wr_baud, w_wr_stat, w_wr_ie;
    logic w_rd_rxd;
    assign w_wr      = uart_sel & uart_wr_enable;
    assign w_rd      = uart_sel & ~uart_wr_enable;
    assign w_wr_ctrl = w_wr && (uart_addr == 4'h0);
    assign w_wr_txd  = w_wr && (uart_addr == 4'h1);
    assign w_wr_baud = w_wr && (uart_addr == 4'h3);
    assign w_wr_stat = w_wr && (uart_addr == 4'h4);
    assign w_wr_ie   = w_wr && (uart_addr == 4'h5);
    assign w_rd_rxd  = w_rd && (uart_addr == 4'h2);

    logic [5:0]  r_ctrl;
    logic [7:0]  r_ie;
    logic [15:0] r_baud;
    logic [15:0] r_baud_cnt;
    logic        r_tx_ovf, r_rx_ovr, r_frame_err, r_par_err;

    logic w_tx_en, w_rx_en, w_par_en, w_par_odd, w_two_stop, w_loop;
    assign w_tx_en    = r_ctrl[0];
    assign w_rx_en    = r_ctrl[1];
    assign w_par_en   = r_ctrl[2];
    assign w_par_odd  = r_ctrl[3];
    assign w_two_stop = r_ctrl[4];
    assign w_loop     = r_ctrl[5];

    // Baud generator: tick every r_baud+1 clocks
    logic w_tick;
    assign w_tick = (r_baud_cnt == 16'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_baud     <= BAUD_RST;
            r_baud_cnt <= BAUD_RST;
        end else if (w_wr_baud) begin
            r_baud     <= wdata_mem[15:0];
            r_baud_cnt <= wdata_mem[15:0];
        end else if (w_tick) begin
            r_baud_cnt <= r_baud;
        end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
        end
    end

    // TX FIFO
    logic [DATA_BITS-1:0] r_txf_mem [TX_DEPTH];
    logic [TAW-1:0]       r_txf_wp, r_txf_rp;
    logic [TAW:0]         r_txf_cnt;
    logic                 w_txf_empty, w_txf_full;
    logic                 w_txf_push, w_txf_ovf, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;

    assign w_txf_empty = (r_txf_cnt == '0);
    assign w_txf_full  = (r_txf_cnt == TX_FULL);
    assign w_tx_head   = r_txf_mem[r_txf_rp];
    // A full FIFO still accepts a write when the TX FSM pops that cycle
    assign w_txf_push  = w_wr_txd && (!w_txf_full || w_tx_pop);
    assign w_txf_ovf   = w_wr_txd && !w_txf_push;

    always_ff @(posedge clock) begin
        if (w_txf_push) r_txf_mem[r_txf_wp] <= wdata_mem[DATA_BITS-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_txf_wp  <= '0;
            r_txf_rp  <= '0;
            r_txf_cnt <= '0;
        end else begin
            if (w_txf_push) r_txf_wp <= r_txf_wp + TAW'(1);
            if (w_tx_pop)   r_txf_rp <= r_txf_rp + TAW'(1);
            if (w_txf_push && !w_tx_pop)
                r_txf_cnt <= r_txf_cnt + (TAW+1)'(1);
            else if (!w_txf_push && w_tx_pop)
                r_txf_cnt <= r_txf_cnt - (TAW+1)'(1);
        end
    end

    // RX FIFO
    logic [DATA_BITS-1:0] r_rxf_mem [RX_DEPTH];
    logic [RAW-1:0]       r_rxf_wp, r_rxf_rp;
    logic [RAW:0]         r_rxf_cnt;
    logic                 w_rxf_empty, w_rxf_full;
    logic                 w_rx_push_req, w_rxf_push, w_rxf_pop, w_rx_ovr;
    logic [DATA_BITS-1:0] w_rx_head;
    logic [DATA_BITS-1:0] r_rx_shift;

    assign w_rxf_empty = (r_rxf_cnt == '0);
    assign w_rxf_full  = (r_rxf_cnt == RX_FULL);
    assign w_rx_head   = r_rxf_mem[r_rxf_rp];
    assign w_rxf_pop   = w_rd_rxd && !w_rxf_empty;
    assign w_rxf_push  = w_rx_push_req && (!w_rxf_full || w_rxf_pop);
    assign w_rx_ovr    = w_rx_push_req && !w_rxf_push;

    always_ff @(posedge clock) begin
        if (w_rxf_push) r_rxf_mem[r_rxf_wp] <= r_rx_shift;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rxf_wp  <= '0;
            r_rxf_rp  <= '0;
            r_rxf_cnt <= '0;
        end else begin
            if (w_rxf_push) r_rxf_wp <= r_rxf_wp + RAW'(1);
            if (w_rxf_pop)  r_rxf_rp <= r_rxf_rp + RAW'(1);
            if (w_rxf_push && !w_rxf_pop)
                r_rxf_cnt <= r_rxf_cnt + (RAW+1)'(1);
            else if (!w_rxf_push && w_rxf_pop)
                r_rxf_cnt <= r_rxf_cnt - (RAW+1)'(1);
        end
    end

    // TX FSM
    state_t               r_tx_state, w_tx_state_n;
    logic [4:0]           r_tx_cnt, w_tx_cnt_n;
    logic [2:0]           r_tx_bitn, w_tx_bitn_n;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
    logic                 r_tx_par, w_tx_par_n;
    logic                 r_tx_line, w_tx_line_n;
    logic                 r_tx_done, w_tx_done_n;
    logic                 w_tx_go, w_tx_bit_end, w_tx_stop_end;

    assign w_tx_go       = w_tx_en && !w_txf_empty;
    assign w_tx_bit_end  = (r_tx_cnt == 5'd15);
    assign w_tx_stop_end = (r_tx_cnt == (w_two_stop ? 5'd31 : 5'd15));

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bitn_n  = r_tx_bitn;
        w_tx_shift_n = r_tx_shift;
        w_tx_par_n   = r_tx_par;
        w_tx_line_n  = r_tx_line;
        w_tx_done_n  = r_tx_done;
        w_tx_pop     = 1'b0;
        if (w_tick) begin
            w_tx_cnt_n = r_tx_cnt + 5'd1;
            unique case (r_tx_state)
                S_IDLE: begin
                    w_tx_cnt_n = 5'd0;
                    w_tx_pop   = w_tx_go;
                end
                S_START: begin
                    if (w_tx_bit_end) begin
                        w_tx_state_n = S_DATA;
                        w_tx_cnt_n   = 5'd0;
                        w_tx_bitn_n  = 3'd0;
                        w_tx_line_n  = r_tx_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_tx_bit_end) begin
                        w_tx_cnt_n = 5'd0;
                        if (r_tx_bitn == LAST_BIT) begin
                            w_tx_state_n = w_par_en ? S_PARITY : S_STOP;
                            w_tx_line_n  = w_par_en ? r_tx_par : 1'b1;
                        end else begin
                            w_tx_bitn_n  = r_tx_bitn + 3'd1;
                            w_tx_shift_n = r_tx_shift >> 1;
                            w_tx_line_n  = r_tx_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tx_bit_end) begin
                        w_tx_state_n = S_STOP;
                        w_tx_cnt_n   = 5'd0;
                        w_tx_line_n  = 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tx_stop_end) begin
                        w_tx_cnt_n = 5'd0;
                        if (w_tx_go) begin
                            w_tx_pop = 1'b1;
                        end else begin
                            w_tx_state_n = S_IDLE;
                            w_tx_done_n  = 1'b1;
                        end
                    end
                end
                default: w_tx_state_n = S_IDLE;
            endcase
            // Loading a character: next state is START, line drops to 0
            if (w_tx_pop) begin
                w_tx_state_n = S_START;
                w_tx_cnt_n   = 5'd0;
                w_tx_shift_n = w_tx_head;
                w_tx_par_n   = (^w_tx_head) ^ w_par_odd;
                w_tx_line_n  = 1'b0;
                w_tx_done_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= 5'd0;
            r_tx_bitn  <= 3'd0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bitn  <= w_tx_bitn_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_par   <= w_tx_par_n;
            r_tx_line  <= w_tx_line_n;
            r_tx_done  <= w_tx_done_n;
        end
    end

    // Loopback keeps the pin idle while the frame goes to RX internally
    assign tx_bit = w_loop | r_tx_line;

    // RX synchroniser and FSM
    logic   r_rx_s1, r_rx_s2, r_rx_prev;
    logic   w_rx_fall;
    state_t r_rx_state, w_rx_state_n;
    logic [3:0]           r_rx_cnt, w_rx_cnt_n;
    logic [2:0]           r_rx_bitn, w_rx_bitn_n;
    logic [DATA_BITS-1:0] w_rx_shift_n;
    logic                 r_rx_xor, w_rx_xor_n;
    logic                 w_rx_ferr, w_rx_perr;

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= w_loop ? r_tx_line : rx_bit;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // START re-aligns the count at mid start bit so later samples hit mid-bit
    always_comb begin
        w_rx_state_n  = r_rx_state;
        w_rx_cnt_n    = r_rx_cnt;
        w_rx_bitn_n   = r_rx_bitn;
        w_rx_shift_n  = r_rx_shift;
        w_rx_xor_n    = r_rx_xor;
        w_rx_push_req = 1'b0;
        w_rx_ferr     = 1'b0;
        w_rx_perr     = 1'b0;
        unique case (r_rx_state)
            S_IDLE: begin
                if (w_rx_en && w_rx_fall) begin
                    w_rx_state_n = S_START;
                    w_rx_cnt_n   = 4'd0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_rx_cnt_n = r_rx_cnt + 4'd1;
                    if (r_rx_cnt == 4'd7) begin
                        w_rx_cnt_n   = 4'd0;
                        w_rx_bitn_n  = 3'd0;
                        w_rx_xor_n   = 1'b0;
                        w_rx_state_n = r_rx_s2 ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_rx_cnt_n = r_rx_cnt + 4'd1;
                    if (r_rx_cnt == 4'd15) begin
                        w_rx_shift_n = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        w_rx_xor_n   = r_rx_xor ^ r_rx_s2;
                        w_rx_bitn_n  = r_rx_bitn + 3'd1;
                        if (r_rx_bitn == LAST_BIT)
                            w_rx_state_n = w_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_rx_cnt_n = r_rx_cnt + 4'd1;
                    if (r_rx_cnt == 4'd15) begin
                        w_rx_perr    = r_rx_s2 ^ r_rx_xor ^ w_par_odd;
                        w_rx_state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_rx_cnt_n = r_rx_cnt + 4'd1;
                    if (r_rx_cnt == 4'd15) begin
                        w_rx_push_req = 1'b1;
                        w_rx_ferr     = ~r_rx_s2;
                        w_rx_state_n  = S_IDLE;
                    end
                end
            end
            default: w_rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= 4'd0;
            r_rx_bitn  <= 3'd0;
            r_rx_shift <= '0;
            r_rx_xor   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bitn  <= w_rx_bitn_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_xor   <= w_rx_xor_n;
        end
    end

    // Control registers and sticky flags (a new set event beats W1C)
    logic [5:0] w_clr;
    assign w_clr = w_wr_stat ? wdata_mem[5:0] : 6'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ctrl      <= 6'h03;
            r_ie        <= 8'h00;
            r_tx_ovf    <= 1'b0;
            r_rx_ovr    <= 1'b0;
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= wdata_mem[5:0];
            if (w_wr_ie)   r_ie   <= wdata_mem[7:0];
            r_tx_ovf    <= w_txf_ovf | (r_tx_ovf & ~w_clr[2]);
            r_rx_ovr    <= w_rx_ovr  | (r_rx_ovr & ~w_clr[3]);
            r_frame_err <= w_rx_ferr | (r_frame_err & ~w_clr[4]);
            r_par_err   <= w_rx_perr | (r_par_err & ~w_clr[5]);
        end
    end

    // tx_idle (b6) flags a completed frame with the line idle; clear until then
    logic [23:0] w_status;
    assign w_status = {
        8'(r_txf_cnt), 8'(r_rxf_cnt),
        w_rxf_full, r_tx_done, r_par_err, r_frame_err,
        r_rx_ovr, r_tx_ovf, w_txf_empty, ~w_rxf_empty
    };

    assign irq = |(w_status[7:0] & r_ie);

    always_comb begin
        uart_data = 32'd0;
        case (uart_addr)
            4'h0: uart_data = {26'd0, r_ctrl};
            4'h2: uart_data = w_rxf_empty ? 32'd0 : 32'(w_rx_head);
            4'h3: uart_data = {16'd0, r_baud};
            4'h4: uart_data = {8'd0, w_status};
            4'h5: uart_data = {24'd0, r_ie};
            default: uart_data = 32'd0;
        endcase
    end
endmodule
